// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH   = 32;
    localparam int unsigned MDU_LATENCY = 33;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MADD  = 3'b100;
    localparam logic [2:0] MDU_MSUB  = 3'b101;
    localparam logic [2:0] MDU_MTHI  = 3'b110;
    localparam logic [2:0] MDU_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } mdu_state_e;

endpackage

// File: rtl/mdu_shift_core.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step,
// both built around a single (WIDTH+1)-bit adder.
module mdu_shift_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_lhs;
    logic [WIDTH:0] w_rhs;
    logic [WIDTH:0] w_sum;
    logic           w_cin;

    always_comb begin
        if (i_is_div) begin
            // Trial subtract of the divisor from the remainder with the next dividend bit.
            w_lhs = {i_hi, i_lo[WIDTH-1]};
            w_rhs = ~{1'b0, i_operand};
            w_cin = 1'b1;
        end else begin
            w_lhs = {1'b0, i_hi};
            w_rhs = i_lo[0] ? {1'b0, i_operand} : '0;
            w_cin = 1'b0;
        end
        w_sum = w_lhs + w_rhs + {{WIDTH{1'b0}}, w_cin};

        if (i_is_div) begin
            if (w_sum[WIDTH]) begin
                o_hi = w_lhs[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end else begin
                o_hi = w_sum[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair; 33-cycle latency for
// every mult/div op, single-cycle MTHI/MTLO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    mdu_state_e         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_p_hi;
    logic [WIDTH-1:0]   r_p_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_is_signed;
    logic               w_is_div_in;
    logic               w_is_md_in;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_launch;
    logic               w_div;
    logic               w_neg;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_wb_hi;
    logic [WIDTH-1:0]   w_wb_lo;
    logic               w_wb_dbz;
    logic [2*WIDTH-1:0] w_acc_src;

    assign w_is_signed = (Op == MDU_MULT) || (Op == MDU_DIV) || (Op == MDU_MADD) ||
                         (Op == MDU_MSUB);
    assign w_is_div_in = (Op == MDU_DIV) || (Op == MDU_DIVU);
    assign w_is_md_in  = (Op != MDU_MTHI) && (Op != MDU_MTLO);
    assign w_sign_a    = w_is_signed & OperandA[WIDTH-1];
    assign w_sign_b    = w_is_signed & OperandB[WIDTH-1];
    assign w_mag_a     = w_sign_a ? -OperandA : OperandA;
    assign w_mag_b     = w_sign_b ? -OperandB : OperandB;
    // A mult/div may launch on the FIX edge so back-to-back ops need no idle bubble.
    assign w_launch    = Start && w_is_md_in && ((r_state == StIdle) || (r_state == StFix));

    assign w_div    = (r_op == MDU_DIV) || (r_op == MDU_DIVU);
    assign w_neg    = r_sign_a ^ r_sign_b;
    assign w_prod   = {r_p_hi, r_p_lo};
    assign w_prod_s = w_neg ? -w_prod : w_prod;
    assign w_quot_s = w_neg ? -r_p_lo : r_p_lo;
    assign w_rem_s  = r_sign_a ? -r_p_hi : r_p_hi;

    mdu_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_is_div (w_div),
        .i_hi     (r_p_hi),
        .i_lo     (r_p_lo),
        .i_operand(r_b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    always_comb begin
        w_wb_hi  = r_hi;
        w_wb_lo  = r_lo;
        w_wb_dbz = 1'b0;
        case (r_op)
            MDU_MULT, MDU_MULTU: {w_wb_hi, w_wb_lo} = w_prod_s;
            MDU_DIV, MDU_DIVU: begin
                if (r_b == '0) begin
                    w_wb_hi  = r_a_raw;
                    w_wb_lo  = '1;
                    w_wb_dbz = 1'b1;
                end else begin
                    w_wb_hi = w_rem_s;
                    w_wb_lo = w_quot_s;
                end
            end
            MDU_MADD: {w_wb_hi, w_wb_lo} = r_acc + w_prod_s;
            MDU_MSUB: {w_wb_hi, w_wb_lo} = r_acc - w_prod_s;
            default: ;
        endcase
    end

    // MADD/MSUB launched on the FIX edge accumulate onto the value being written there.
    assign w_acc_src = (r_state == StFix) ? {w_wb_hi, w_wb_lo} : {r_hi, r_lo};

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op     <= MDU_MULT;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_raw  <= '0;
            r_b      <= '0;
            r_p_hi   <= '0;
            r_p_lo   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (Flush) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (Start && (Op == MDU_MTHI)) r_hi <= OperandA;
                        if (Start && (Op == MDU_MTLO)) r_lo <= OperandA;
                    end
                    StCalc: begin
                        r_p_hi <= w_core_hi;
                        r_p_lo <= w_core_lo;
                        r_cnt  <= r_cnt - CW'(1);
                        if (r_cnt == '0) r_state <= StFix;
                    end
                    StFix: begin
                        r_hi    <= w_wb_hi;
                        r_lo    <= w_wb_lo;
                        r_done  <= 1'b1;
                        r_dbz   <= w_wb_dbz;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase

                if (w_launch) begin
                    r_state  <= StCalc;
                    r_busy   <= 1'b1;
                    r_cnt    <= CW'(WIDTH - 1);
                    r_op     <= Op;
                    r_sign_a <= w_sign_a;
                    r_sign_b <= w_sign_b;
                    r_a_raw  <= OperandA;
                    r_acc    <= w_acc_src;
                    r_p_hi   <= '0;
                    if (w_is_div_in) begin
                        r_p_lo <= w_mag_a;
                        r_b    <= w_mag_b;
                    end else begin
                        r_p_lo <= w_mag_b;
                        r_b    <= w_mag_a;
                    end
                end
            end
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign Hi        = r_hi;
    assign Lo        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit #(
        .WIDTH(32)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .Flush    (Flush),
        .Busy     (Busy),
        .Done     (Done),
        .DivByZero(DivByZero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op and wait (bounded) for Done; reports latency, busy cycles, DivByZero.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output logic dbz);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        tick();
        Start = 1'b0;
        lat = 0; dbz = 1'b0; busy_cnt = 0;
        if (Busy) busy_cnt++;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (Busy) busy_cnt++;
            if (Done) begin
                lat = i;
                dbz = DivByZero;
                break;
            end
        end
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] v);
        Start = 1'b1; Op = op; OperandA = v; OperandB = '0;
        tick();
        Start = 1'b0;
    endtask

    int   lat;
    int   bcnt;
    logic dbz;
    logic seen_done;

    initial begin
        Reset = 1'b0; Start = 1'b0; Op = 3'b000; OperandA = '0; OperandB = '0; Flush = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        chk("reset_hi", Hi, 32'h0);
        chk("reset_lo", Lo, 32'h0);
        chk("reset_busy", {31'b0, Busy}, 32'h0);
        chk("reset_done", {31'b0, Done}, 32'h0);
        chk("reset_dbz", {31'b0, DivByZero}, 32'h0);

        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, dbz);
        chk("multu_hi", Hi, 32'hFFFFFFFE);
        chk("multu_lo", Lo, 32'h00000001);
        chk("multu_latency", lat, 33);
        chk("multu_busy_cycles", bcnt, 33);
        chk("multu_busy_at_done", {31'b0, Busy}, 32'h0);

        run_op(3'b000, 32'hFFFFFFFD, 32'd7, lat, bcnt, dbz);
        chk("mult_hi", Hi, 32'hFFFFFFFF);
        chk("mult_lo", Lo, 32'hFFFFFFEB);

        move_to(3'b110, 32'h0);
        chk("mthi_no_done", {31'b0, Done}, 32'h0);
        move_to(3'b111, 32'hFFFFFFFF);
        chk("mtlo_lo", Lo, 32'hFFFFFFFF);
        run_op(3'b100, 32'd1, 32'd1, lat, bcnt, dbz);
        chk("madd_hi", Hi, 32'h00000001);
        chk("madd_lo", Lo, 32'h00000000);

        move_to(3'b110, 32'h0);
        move_to(3'b111, 32'h0);
        run_op(3'b101, 32'd2, 32'd3, lat, bcnt, dbz);
        chk("msub_hi", Hi, 32'hFFFFFFFF);
        chk("msub_lo", Lo, 32'hFFFFFFFA);

        run_op(3'b010, 32'hFFFFFFF9, 32'd2, lat, bcnt, dbz);
        chk("div_neg_lo", Lo, 32'hFFFFFFFD);
        chk("div_neg_hi", Hi, 32'hFFFFFFFF);
        chk("div_neg_dbz", {31'b0, dbz}, 32'h0);

        run_op(3'b011, 32'd100, 32'd7, lat, bcnt, dbz);
        chk("divu_lo", Lo, 32'h0000000E);
        chk("divu_hi", Hi, 32'h00000002);

        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, dbz);
        chk("div_ovf_lo", Lo, 32'h80000000);
        chk("div_ovf_hi", Hi, 32'h00000000);

        run_op(3'b011, 32'h12345678, 32'h0, lat, bcnt, dbz);
        chk("dbz_hi", Hi, 32'h12345678);
        chk("dbz_lo", Lo, 32'hFFFFFFFF);
        chk("dbz_pulse", {31'b0, dbz}, 32'h1);
        chk("dbz_latency", lat, 33);
        tick();
        chk("dbz_one_cycle", {31'b0, DivByZero}, 32'h0);

        // Flush mid-divide, with an ignored MTHI start while busy.
        Start = 1'b1; Op = 3'b010; OperandA = 32'd100; OperandB = 32'd7;
        tick();
        Start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 4) begin
                Start = 1'b1; Op = 3'b110; OperandA = 32'hCAFEF00D;
            end
            tick();
            Start = 1'b0;
        end
        chk("busy_before_flush", {31'b0, Busy}, 32'h1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("flush_busy", {31'b0, Busy}, 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done || Busy) seen_done = 1'b1;
        end
        chk("flush_no_done", {31'b0, seen_done}, 32'h0);
        chk("flush_hi", Hi, 32'h12345678);
        chk("flush_lo", Lo, 32'hFFFFFFFF);

        // Flush and Start together in idle: Start dropped.
        Flush = 1'b1; Start = 1'b1; Op = 3'b110; OperandA = 32'h55AA55AA;
        tick();
        Flush = 1'b0; Start = 1'b0;
        chk("flush_start_busy", {31'b0, Busy}, 32'h0);
        chk("flush_start_hi", Hi, 32'h12345678);
        Flush = 1'b1; Start = 1'b1; Op = 3'b001; OperandA = 32'd5; OperandB = 32'd5;
        tick();
        Flush = 1'b0; Start = 1'b0;
        tick();
        chk("flush_start_mul_busy", {31'b0, Busy}, 32'h0);

        // Reset mid-operation.
        Start = 1'b1; Op = 3'b000; OperandA = 32'd3; OperandB = 32'd4;
        tick();
        Start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk("rst_mid_hi", Hi, 32'h0);
        chk("rst_mid_lo", Lo, 32'h0);
        chk("rst_mid_busy", {31'b0, Busy}, 32'h0);

        move_to(3'b110, 32'hDEADBEEF);
        chk("mthi_hi", Hi, 32'hDEADBEEF);
        chk("mthi_lo_kept", Lo, 32'h0);
        chk("mthi_done", {31'b0, Done}, 32'h0);
        chk("mthi_busy", {31'b0, Busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
